morse_tx: RTL

MORSE_TX -- requirements
Module: morse_tx

---
 rtl/morse_pkg.sv | 86 ++++++++
 rtl/morse_lut.sv | 19 +
 rtl/morse_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter: letter indices, FSM states,
// element limits and the letter-to-code table.
package morse_pkg;

  localparam int MAX_ELEMS = 4;
  localparam int LEN_W     = $clog2(MAX_ELEMS + 1);
  // Three units of the largest legal UNIT_CYCLES (2^24-1) need 26 bits.
  localparam int TIMER_W   = 26;

  localparam logic [4:0] A_M = 5'd0;
  localparam logic [4:0] B_M = 5'd1;
  localparam logic [4:0] C_M = 5'd2;
  localparam logic [4:0] D_M = 5'd3;
  localparam logic [4:0] E_M = 5'd4;
  localparam logic [4:0] F_M = 5'd5;
  localparam logic [4:0] G_M = 5'd6;
  localparam logic [4:0] H_M = 5'd7;
  localparam logic [4:0] I_M = 5'd8;
  localparam logic [4:0] J_M = 5'd9;
  localparam logic [4:0] K_M = 5'd10;
  localparam logic [4:0] L_M = 5'd11;
  localparam logic [4:0] M_M = 5'd12;
  localparam logic [4:0] N_M = 5'd13;
  localparam logic [4:0] O_M = 5'd14;
  localparam logic [4:0] P_M = 5'd15;
  localparam logic [4:0] Q_M = 5'd16;
  localparam logic [4:0] R_M = 5'd17;
  localparam logic [4:0] S_M = 5'd18;
  localparam logic [4:0] T_M = 5'd19;
  localparam logic [4:0] U_M = 5'd20;
  localparam logic [4:0] V_M = 5'd21;
  localparam logic [4:0] W_M = 5'd22;
  localparam logic [4:0] X_M = 5'd23;
  localparam logic [4:0] Y_M = 5'd24;
  localparam logic [4:0] Z_M = 5'd25;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    GAP      = 2'd2,
    CHAR_GAP = 2'd3
  } state_t;

  // Pattern is left-aligned: bit [MAX_ELEMS-1] is the first element, 1 = dash.
  typedef struct packed {
    logic                 illegal;
    logic [LEN_W-1:0]     len;
    logic [MAX_ELEMS-1:0] pattern;
  } morse_code_t;

  function automatic morse_code_t morse_lookup(input logic [4:0] letter);
    morse_code_t code;
    code = {1'b1, 3'd0, 4'b0000};
    case (letter)
      A_M:     code = {1'b0, 3'd2, 4'b0100};
      B_M:     code = {1'b0, 3'd4, 4'b1000};
      C_M:     code = {1'b0, 3'd4, 4'b1010};
      D_M:     code = {1'b0, 3'd3, 4'b1000};
      E_M:     code = {1'b0, 3'd1, 4'b0000};
      F_M:     code = {1'b0, 3'd4, 4'b0010};
      G_M:     code = {1'b0, 3'd3, 4'b1100};
      H_M:     code = {1'b0, 3'd4, 4'b0000};
      I_M:     code = {1'b0, 3'd2, 4'b0000};
      J_M:     code = {1'b0, 3'd4, 4'b0111};
      K_M:     code = {1'b0, 3'd3, 4'b1010};
      L_M:     code = {1'b0, 3'd4, 4'b0100};
      M_M:     code = {1'b0, 3'd2, 4'b1100};
      N_M:     code = {1'b0, 3'd2, 4'b1000};
      O_M:     code = {1'b0, 3'd3, 4'b1110};
      P_M:     code = {1'b0, 3'd4, 4'b0110};
      Q_M:     code = {1'b0, 3'd4, 4'b1101};
      R_M:     code = {1'b0, 3'd3, 4'b0100};
      S_M:     code = {1'b0, 3'd3, 4'b0000};
      T_M:     code = {1'b0, 3'd1, 4'b1000};
      U_M:     code = {1'b0, 3'd3, 4'b0010};
      V_M:     code = {1'b0, 3'd4, 4'b0001};
      W_M:     code = {1'b0, 3'd3, 4'b0110};
      X_M:     code = {1'b0, 3'd4, 4'b1001};
      Y_M:     code = {1'b0, 3'd4, 4'b1011};
      Z_M:     code = {1'b0, 3'd4, 4'b1100};
      default: code = {1'b1, 3'd0, 4'b0000};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational letter decoder: index -> element count, left-aligned pattern,
// and an illegal flag for indices 26..31.
module morse_lut
  import morse_pkg::*;
(
  input  logic [4:0] letter_in,
  output logic [2:0] len,
  output logic [3:0] pattern,
  output logic       illegal
);

  morse_code_t code;

  assign code    = morse_lookup(letter_in);
  assign len     = code.len;
  assign pattern = code.pattern;
  assign illegal = code.illegal;

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: accepts one letter at a time and keys its ITU pattern with
// dot = 1 unit, dash = 3 units, element gap = 1 unit, character gap = 3 units.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] letter_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       key_out,
  output logic       busy,
  output logic       err
);

  // Counter reload values; the timer counts down to 0, so n units load n*U-1.
  localparam logic [TIMER_W-1:0] ONE_UNIT   = TIMER_W'(UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] THREE_UNIT = TIMER_W'(3 * UNIT_CYCLES - 1);

  state_t             state, state_n;
  logic [TIMER_W-1:0] cnt, cnt_n;
  logic [2:0]         len, len_n;
  logic [3:0]         pat, pat_n;
  logic               err_n;

  logic [2:0]         lut_len;
  logic [3:0]         lut_pat;
  logic               lut_illegal;

  morse_lut u_lut (
    .letter_in (letter_in),
    .len       (lut_len),
    .pattern   (lut_pat),
    .illegal   (lut_illegal)
  );

  // Next-state, timer reload and element bookkeeping.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    pat_n   = pat;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in && ready_out) begin
          if (lut_illegal) begin
            err_n = 1'b1;
          end else begin
            state_n = MARK;
            len_n   = lut_len;
            pat_n   = lut_pat;
            cnt_n   = lut_pat[3] ? THREE_UNIT : ONE_UNIT;
          end
        end else begin
          cnt_n = '0;
        end
      end
      MARK: begin
        if (cnt == '0) begin
          pat_n = {pat[2:0], 1'b0};
          len_n = len - 3'd1;
          if (len == 3'd1) begin
            state_n = CHAR_GAP;
            cnt_n   = THREE_UNIT;
          end else begin
            state_n = GAP;
            cnt_n   = ONE_UNIT;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = MARK;
          cnt_n   = pat[3] ? THREE_UNIT : ONE_UNIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CHAR_GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        len_n   = 3'd0;
        pat_n   = 4'b0000;
      end
    endcase
  end

  // State, timer, element registers and outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= 3'd0;
      pat       <= 4'b0000;
      key_out   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ready_out <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len       <= len_n;
      pat       <= pat_n;
      key_out   <= (state_n == MARK);
      busy      <= (state_n != IDLE);
      err       <= err_n;
      ready_out <= (state_n == IDLE);
    end
  end

endmodule
